// File: rtl/riscv_rsb.sv
// riscv_rsb: Return Stack Buffer for the RISC-V ID stage.
// It watches each decoded instruction and does one of three things:
//   - pushes the link address on calls;
//   - pops on returns;
//   - replaces the top entry on coroutine swaps.
// The top-of-stack entry is offered to the branch unit as the return prediction.
//
// Ports:
//   clk_i         clock
//   rst_i         synchronous active-high reset (clears pointers and entries)
//   stall_i       ID stalled; the instruction is ignored
//   flush_i       pipeline flush; empties the stack (entries kept)
//   insn_valid_i  insn_i / insn_pc_i carry a real instruction
//   insn_pc_i     PC of insn_i
//   insn_i        instruction; bits[1:0] != 2'b11 means 16-bit in bits[15:0]
//   rsb_pc_o      predicted return address (entry at tos)
//   rsb_valid_o   stack is non-empty
module riscv_rsb #(
  parameter int XLEN      = 32,
  parameter int RSB_DEPTH = 4,
  parameter int HAS_RVC   = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            insn_valid_i,
  input  logic [XLEN-1:0] insn_pc_i,
  input  logic [31:0]     insn_i,
  output logic [XLEN-1:0] rsb_pc_o,
  output logic            rsb_valid_o
);

  localparam int PTR_W = $clog2(RSB_DEPTH);
  localparam int CNT_W = $clog2(RSB_DEPTH + 1);

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_PUSH,
    ACT_POP,
    ACT_POPPUSH
  } act_e;

  logic [XLEN-1:0]  entries [RSB_DEPTH];
  logic [PTR_W-1:0] tos;
  logic [PTR_W-1:0] tos_inc;
  logic [CNT_W-1:0] cnt;

  act_e            action;
  logic            is_16;
  logic [XLEN-1:0] push_val;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] c_rs1;
  logic [4:0] c_rs2;
  logic       rd_link;
  logic       rs1_link;
  logic       c_rs1_link;

  // Immediate fields of 32-bit jumps play no part in the prediction.
  logic unused_bits;
  assign unused_bits = &{1'b0, insn_i[31:20]};

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  assign is_16      = (insn_i[1:0] != 2'b11);
  assign opcode     = insn_i[6:0];
  assign rd         = insn_i[11:7];
  assign rs1        = insn_i[19:15];
  assign c_rs1      = insn_i[11:7];
  assign c_rs2      = insn_i[6:2];
  assign rd_link    = is_link(rd);
  assign rs1_link   = is_link(rs1);
  assign c_rs1_link = is_link(c_rs1);

  assign push_val = insn_pc_i + (is_16 ? XLEN'(2) : XLEN'(4));
  assign tos_inc  = tos + PTR_W'(1);

  // Call/return classification from the RISC-V link-register hint rules.
  // C.JALR always links through x1, so rs1=x5 is a swap and rs1=x1 a plain push.
  always_comb begin
    action = ACT_NONE;
    if (!is_16) begin
      if (opcode == 7'b1101111) begin
        if (rd_link) action = ACT_PUSH;
      end else if (opcode == 7'b1100111) begin
        if (!rd_link && rs1_link)                  action = ACT_POP;
        else if (rd_link && !rs1_link)             action = ACT_PUSH;
        else if (rd_link && rs1_link && rd != rs1) action = ACT_POPPUSH;
        else if (rd_link)                          action = ACT_PUSH;
      end
    end else if (HAS_RVC != 0) begin
      if (XLEN == 32 && insn_i[15:13] == 3'b001 && insn_i[1:0] == 2'b01) begin
        action = ACT_PUSH;
      end else if (insn_i[1:0] == 2'b10 && c_rs1 != 5'd0 && c_rs2 == 5'd0) begin
        if (insn_i[15:12] == 4'b1000 && c_rs1_link) begin
          action = ACT_POP;
        end else if (insn_i[15:12] == 4'b1001) begin
          action = (c_rs1 == 5'd5) ? ACT_POPPUSH : ACT_PUSH;
        end
      end
    end
  end

  // Circular stack: a push on a full stack silently overwrites the oldest
  // entry, because tos simply wraps onto it. Flush empties the stack by
  // pointer only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tos <= '0;
      cnt <= '0;
      for (int i = 0; i < RSB_DEPTH; i++) entries[i] <= '0;
    end else if (flush_i) begin
      tos <= '0;
      cnt <= '0;
    end else if (!stall_i && insn_valid_i) begin
      unique case (action)
        ACT_PUSH: begin
          tos              <= tos_inc;
          entries[tos_inc] <= push_val;
          if (cnt != CNT_W'(RSB_DEPTH)) cnt <= cnt + CNT_W'(1);
        end
        ACT_POP: begin
          if (cnt != '0) begin
            tos <= tos - PTR_W'(1);
            cnt <= cnt - CNT_W'(1);
          end
        end
        ACT_POPPUSH: begin
          entries[tos] <= push_val;
          if (cnt == '0) cnt <= CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rsb_pc_o    = entries[tos];
  assign rsb_valid_o = (cnt != '0);

endmodule

// File: tb/tb_riscv_rsb.sv
// tb_riscv_rsb: self-checking bench for riscv_rsb.
// Two instances share the stimulus: one built with HAS_RVC=1 and one with
// HAS_RVC=0. A stack model kept in plain integers tracks each of them.
// A table of directed cycles carries hand-derived expected values for the
// RVC instance. A hand-written overflow sequence follows, and then a
// randomized run that is checked only against the model.
module tb_riscv_rsb;

  localparam int DEPTH = 4;

  localparam int A_NONE    = 0;
  localparam int A_PUSH    = 1;
  localparam int A_POP     = 2;
  localparam int A_POPPUSH = 3;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] JAL_X1    = 32'h0000_00EF;
  localparam logic [31:0] JAL_X5    = 32'h0000_02EF;
  localparam logic [31:0] RET       = 32'h0000_8067;
  localparam logic [31:0] JALR_1_5  = 32'h0002_80E7;
  localparam logic [31:0] JALR_1_1  = 32'h0000_80E7;
  localparam logic [31:0] C_JALR_X5 = 32'h0000_9282;
  localparam logic [31:0] C_JALR_X1 = 32'h0000_9082;
  localparam logic [31:0] C_JR_X1   = 32'h0000_8082;
  localparam logic [31:0] C_JAL     = 32'h0000_2001;

  logic        clk = 1'b0;
  logic        rst, stall, flush, insn_valid;
  logic [31:0] insn_pc, insn;
  logic [31:0] pc_rvc, pc_norvc;
  logic        valid_rvc, valid_norvc;

  always #5 clk = ~clk;

  riscv_rsb #(.XLEN(32), .RSB_DEPTH(DEPTH), .HAS_RVC(1)) dut_rvc (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .insn_valid_i(insn_valid), .insn_pc_i(insn_pc), .insn_i(insn),
    .rsb_pc_o(pc_rvc), .rsb_valid_o(valid_rvc)
  );

  riscv_rsb #(.XLEN(32), .RSB_DEPTH(DEPTH), .HAS_RVC(0)) dut_norvc (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .insn_valid_i(insn_valid), .insn_pc_i(insn_pc), .insn_i(insn),
    .rsb_pc_o(pc_norvc), .rsb_valid_o(valid_norvc)
  );

  // Reference stacks: index 0 follows dut_rvc, index 1 follows dut_norvc.
  int          m_tos [2];
  int          m_cnt [2];
  logic [31:0] m_ent [2][DEPTH];

  int checks = 0;
  int passes = 0;

  typedef struct {
    bit          r, f, s, v;
    logic [31:0] pc, ins, exp_pc;
    bit          exp_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit f, bit s, bit v, logic [31:0] pc,
                              logic [31:0] ins, logic [31:0] exp_pc, bit exp_valid);
    vec_t t;
    t.r = r; t.f = f; t.s = s; t.v = v;
    t.pc = pc; t.ins = ins; t.exp_pc = exp_pc; t.exp_valid = exp_valid;
    return t;
  endfunction

  function automatic bit link_reg(int r);
    return (r == 1) || (r == 5);
  endfunction

  function automatic int classify(logic [31:0] ins, bit rvc);
    int rd, rs1, crs1, crs2;
    if (ins[1:0] == 2'b11) begin
      rd  = int'(ins[11:7]);
      rs1 = int'(ins[19:15]);
      if (ins[6:0] == 7'b1101111) return link_reg(rd) ? A_PUSH : A_NONE;
      if (ins[6:0] == 7'b1100111) begin
        if (link_reg(rd) && link_reg(rs1)) return (rd == rs1) ? A_PUSH : A_POPPUSH;
        if (link_reg(rd))  return A_PUSH;
        if (link_reg(rs1)) return A_POP;
      end
      return A_NONE;
    end
    if (!rvc) return A_NONE;
    if (ins[15:13] == 3'b001 && ins[1:0] == 2'b01) return A_PUSH;
    crs1 = int'(ins[11:7]);
    crs2 = int'(ins[6:2]);
    if (ins[1:0] == 2'b10 && crs1 != 0 && crs2 == 0) begin
      if (ins[15:12] == 4'b1000) return link_reg(crs1) ? A_POP : A_NONE;
      if (ins[15:12] == 4'b1001) return (crs1 == 5) ? A_POPPUSH : A_PUSH;
    end
    return A_NONE;
  endfunction

  task automatic model_step(input int m, input bit rvc);
    logic [31:0] pv;
    int          act;
    pv  = insn_pc + ((insn[1:0] == 2'b11) ? 32'd4 : 32'd2);
    act = classify(insn, rvc);
    if (rst) begin
      m_tos[m] = 0;
      m_cnt[m] = 0;
      for (int i = 0; i < DEPTH; i++) m_ent[m][i] = '0;
    end else if (flush) begin
      m_tos[m] = 0;
      m_cnt[m] = 0;
    end else if (!stall && insn_valid) begin
      if (act == A_PUSH) begin
        m_tos[m] = (m_tos[m] + 1) % DEPTH;
        m_ent[m][m_tos[m]] = pv;
        if (m_cnt[m] < DEPTH) m_cnt[m]++;
      end else if (act == A_POP) begin
        if (m_cnt[m] > 0) begin
          m_tos[m] = (m_tos[m] + DEPTH - 1) % DEPTH;
          m_cnt[m]--;
        end
      end else if (act == A_POPPUSH) begin
        m_ent[m][m_tos[m]] = pv;
        if (m_cnt[m] == 0) m_cnt[m] = 1;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit f, input bit s, input bit v,
                               input logic [31:0] pc, input logic [31:0] ins);
    rst = r; flush = f; stall = s; insn_valid = v; insn_pc = pc; insn = ins;
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_one(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  task automatic checkOutput(input string tag);
    check_one({tag, "/rvc_pc"},      pc_rvc,               m_ent[0][m_tos[0]]);
    check_one({tag, "/rvc_valid"},   {31'b0, valid_rvc},   {31'b0, m_cnt[0] != 0});
    check_one({tag, "/norvc_pc"},    pc_norvc,             m_ent[1][m_tos[1]]);
    check_one({tag, "/norvc_valid"}, {31'b0, valid_norvc}, {31'b0, m_cnt[1] != 0});
  endtask

  function automatic logic [4:0] pick_reg();
    int sel;
    sel = int'($urandom_range(0, 4));
    case (sel)
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      3: return 5'd6;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] random_insn();
    int          kind;
    logic [31:0] w;
    w    = $urandom;
    kind = int'($urandom_range(0, 6));
    case (kind)
      0: return {w[31:12], pick_reg(), 7'b1101111};
      1: return {w[31:20], pick_reg(), 3'b000, pick_reg(), 7'b1100111};
      2: return {w[31:16], 4'b1000, pick_reg(), ($urandom_range(0, 3) == 0) ? 5'(w[6:2]) : 5'd0, 2'b10};
      3: return {w[31:16], 4'b1001, pick_reg(), ($urandom_range(0, 3) == 0) ? 5'(w[6:2]) : 5'd0, 2'b10};
      4: return {w[31:16], 3'b001, w[12:2], 2'b01};
      5: return NOP;
      default: return w;
    endcase
  endfunction

  initial begin
    logic [31:0] ovf_exp [3];
    rst = 1'b0; flush = 1'b0; stall = 1'b0; insn_valid = 1'b0;
    insn_pc = '0; insn = NOP;

    // Directed cycles: {rst, flush, stall, valid, pc, insn} -> {rsb_pc, rsb_valid} of dut_rvc.
    vecs.push_back(mk(1, 0, 0, 1, 32'h100,  JAL_X1,    32'h0,    0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,    NOP,       32'h0,    0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,    JAL_X1,    32'h0,    0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h100,  JAL_X1,    32'h104,  1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h104,  RET,       32'h0,    0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h100,  JAL_X1,    32'h104,  1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h200,  JAL_X1,    32'h204,  1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h300,  JAL_X1,    32'h304,  1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h400,  JAL_X1,    32'h404,  1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h500,  JAL_X1,    32'h504,  1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h700,  RET,       32'h404,  1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h700,  RET,       32'h304,  1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h700,  RET,       32'h204,  1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h700,  RET,       32'h504,  0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h700,  RET,       32'h504,  0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h600,  JAL_X1,    32'h604,  1));
    vecs.push_back(mk(0, 1, 0, 1, 32'h0,    NOP,       32'h404,  0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h100,  JAL_X1,    32'h104,  1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h200,  JALR_1_5,  32'h204,  1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h300,  RET,       32'h404,  0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h200,  JALR_1_5,  32'h204,  1));
    vecs.push_back(mk(0, 0, 1, 1, 32'h100,  JAL_X1,    32'h204,  1));
    vecs.push_back(mk(0, 1, 1, 1, 32'h100,  JAL_X1,    32'h204,  0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h300,  JAL_X1,    32'h304,  1));
    vecs.push_back(mk(1, 0, 0, 1, 32'h300,  JAL_X1,    32'h0,    0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h1002, C_JALR_X5, 32'h1004, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h2000, C_JAL,     32'h2002, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h2100, C_JR_X1,   32'h1004, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h2100, C_JR_X1,   32'h0,    0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h3000, C_JALR_X1, 32'h3002, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFC, JAL_X5, 32'h0,  1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h40,   JALR_1_1,  32'h44,   1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h80,   JAL_X1,    32'h44,   1));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].f, vecs[i].s, vecs[i].v, vecs[i].pc, vecs[i].ins);
      check_one($sformatf("vec%0d/pc", i), pc_rvc, vecs[i].exp_pc);
      check_one($sformatf("vec%0d/valid", i), {31'b0, valid_rvc}, {31'b0, vecs[i].exp_valid});
      checkOutput($sformatf("vec%0d/model", i));
    end

    // Six calls into a four-entry stack, then four returns: the two oldest
    // calls are gone, so the stack reads empty after the fourth return.
    applyStimulus(1, 0, 0, 0, 32'h0, NOP);
    for (int i = 1; i <= 6; i++) applyStimulus(0, 0, 0, 1, 32'(i * 16), JAL_X1);
    check_one("ovf/top", pc_rvc, 32'h64);
    check_one("ovf/full_valid", {31'b0, valid_rvc}, 32'd1);
    ovf_exp[0] = 32'h54; ovf_exp[1] = 32'h44; ovf_exp[2] = 32'h34;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 32'h900, RET);
      check_one($sformatf("ovf/pop%0d_pc", i), pc_rvc, ovf_exp[i]);
      check_one($sformatf("ovf/pop%0d_valid", i), {31'b0, valid_rvc}, 32'd1);
    end
    applyStimulus(0, 0, 0, 1, 32'h900, RET);
    check_one("ovf/empty", {31'b0, valid_rvc}, 32'd0);
    checkOutput("ovf/model");

    // Randomized traffic biased toward call/return encodings.
    applyStimulus(1, 0, 0, 0, 32'h0, NOP);
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) != 0),
                    {$urandom} & 32'hFFFF_FFFE,
                    random_insn());
      checkOutput($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
